// File: rtl/dma_arbiter_if.sv
// One DMA-style access channel: request fields driven by the master, accept / response
// fields driven by the slave. Used for both arbiter inputs and the shared core port.
//   addr  : word address [15:1]
//   din   : write data
//   en    : access request
//   we    : byte write enables
//   pri   : DMA priority hint passed through to the core
//   ready : access accepted this cycle
//   resp  : read response valid (one cycle after acceptance)
//   dout  : read data, valid with resp
interface dma_arbiter_if;
    logic [14:0] addr;
    logic [15:0] din;
    logic        en;
    logic [1:0]  we;
    logic        pri;
    logic        ready;
    logic        resp;
    logic [15:0] dout;

    modport master (
        output addr, din, en, we, pri,
        input  ready, resp, dout
    );

    modport slave (
        input  addr, din, en, we, pri,
        output ready, resp, dout
    );
endinterface

// File: rtl/dma_arbiter.sv
// Two-master arbiter in front of the single openMSP430 DMA port.
// The grant is registered, so a request needs one cycle to reach the core, and the grant
// cannot move while the owner is stalled on dma.ready. Read responses follow the master
// whose access was accepted, even if the grant has already moved on.
// Ports:
//   mclk, reset_n : clock, asynchronous active-low reset
//   m0, m1        : master channels (arbiter is the slave)
//   dma           : core DMA port (arbiter is the master)
//   arb_owner     : {grant valid, owner index}
// Parameters:
//   PRIORITY_MODE : 0 = round-robin, 1 = fixed priority with master 0 winning ties
//   MAX_BURST     : accepted beats before yielding to a waiting master, 0 = unlimited
module dma_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned MAX_BURST     = 4
) (
    input  logic          mclk,
    input  logic          reset_n,
    dma_arbiter_if.slave  m0,
    dma_arbiter_if.slave  m1,
    dma_arbiter_if.master dma,
    output logic [1:0]    arb_owner
);

    // Encoding doubles as {grant_vld, owner}.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b10,
        StOwn1 = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       resp_vld_q, resp_vld_d;
    logic       resp_own_q, resp_own_d;

    logic       grant_vld;
    logic       owner;
    logic       own_en;
    logic       oth_en;
    logic       accept;
    logic       arb_idx;
    logic [8:0] beat_next;

    assign grant_vld = state_q[1];
    assign owner     = state_q[0];

    always_comb begin
        own_en    = owner ? m1.en : m0.en;
        oth_en    = owner ? m0.en : m1.en;
        accept    = grant_vld & own_en & dma.ready;
        beat_next = {1'b0, beat_cnt_q} + 9'd1;

        // Winner if arbitration happens this cycle.
        if (m0.en && m1.en) begin
            arb_idx = (PRIORITY_MODE == 1) ? 1'b0 : ~last_q;
        end else begin
            arb_idx = m1.en;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        resp_vld_d = accept;
        resp_own_d = accept ? owner : resp_own_q;

        if (!grant_vld || !own_en) begin
            // Idle, or owner released: arbitrate among whoever is requesting now.
            if (m0.en || m1.en) begin
                state_d    = arb_idx ? StOwn1 : StOwn0;
                last_d     = arb_idx;
                beat_cnt_d = 8'd0;
            end else begin
                state_d = StIdle;
            end
        end else if (dma.ready) begin
            if (MAX_BURST != 0 && beat_next >= 9'(MAX_BURST) && oth_en) begin
                state_d    = owner ? StOwn0 : StOwn1;
                last_d     = ~owner;
                beat_cnt_d = 8'd0;
            end else begin
                beat_cnt_d = beat_next[8] ? 8'hFF : beat_next[7:0];
            end
        end
        // Owner stalled on dma.ready: everything holds.
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            last_q     <= 1'b0;
            beat_cnt_q <= 8'd0;
            resp_vld_q <= 1'b0;
            resp_own_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            resp_vld_q <= resp_vld_d;
            resp_own_q <= resp_own_d;
        end
    end

    always_comb begin
        dma.en   = grant_vld & own_en;
        dma.addr = grant_vld ? (owner ? m1.addr : m0.addr) : 15'd0;
        dma.din  = grant_vld ? (owner ? m1.din  : m0.din)  : 16'd0;
        dma.we   = grant_vld ? (owner ? m1.we   : m0.we)   : 2'd0;
        dma.pri  = grant_vld ? (owner ? m1.pri  : m0.pri)  : 1'b0;

        m0.ready = dma.ready & grant_vld & ~owner & m0.en;
        m1.ready = dma.ready & grant_vld &  owner & m1.en;

        // resp_vld_q drops on reset, discarding any response still in flight.
        m0.resp  = dma.resp & resp_vld_q & ~resp_own_q;
        m1.resp  = dma.resp & resp_vld_q &  resp_own_q;
        m0.dout  = m0.resp ? dma.dout : 16'd0;
        m1.dout  = m1.resp ? dma.dout : 16'd0;

        arb_owner = state_q;
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter. Three instances share one stimulus:
//   a: round-robin, burst 4  (vector table, stall lock, handover response, reset)
//   b: round-robin, burst 1  (alternation)
//   c: fixed priority, unlimited burst
// Each instance has its own small core model answering reads one cycle after acceptance.
module tb_dma_arbiter;

    logic mclk = 1'b0;
    logic reset_n;
    always #5 mclk = ~mclk;

    logic [14:0] m0_addr, m1_addr;
    logic [15:0] m0_din, m1_din;
    logic        m0_en, m1_en;
    logic [1:0]  m0_we, m1_we;
    logic        m0_pri, m1_pri;
    logic        dma_ready;

    logic [1:0]  a_owner, b_owner, c_owner;

    int checks = 0;
    int errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    dma_arbiter_if a_m0 ();
    dma_arbiter_if a_m1 ();
    dma_arbiter_if a_dma ();
    dma_arbiter_if b_m0 ();
    dma_arbiter_if b_m1 ();
    dma_arbiter_if b_dma ();
    dma_arbiter_if c_m0 ();
    dma_arbiter_if c_m1 ();
    dma_arbiter_if c_dma ();

    assign {a_m0.addr, a_m0.din, a_m0.en, a_m0.we, a_m0.pri} = {m0_addr, m0_din, m0_en, m0_we, m0_pri};
    assign {a_m1.addr, a_m1.din, a_m1.en, a_m1.we, a_m1.pri} = {m1_addr, m1_din, m1_en, m1_we, m1_pri};
    assign {b_m0.addr, b_m0.din, b_m0.en, b_m0.we, b_m0.pri} = {m0_addr, m0_din, m0_en, m0_we, m0_pri};
    assign {b_m1.addr, b_m1.din, b_m1.en, b_m1.we, b_m1.pri} = {m1_addr, m1_din, m1_en, m1_we, m1_pri};
    assign {c_m0.addr, c_m0.din, c_m0.en, c_m0.we, c_m0.pri} = {m0_addr, m0_din, m0_en, m0_we, m0_pri};
    assign {c_m1.addr, c_m1.din, c_m1.en, c_m1.we, c_m1.pri} = {m1_addr, m1_din, m1_en, m1_we, m1_pri};
    assign a_dma.ready = dma_ready;
    assign b_dma.ready = dma_ready;
    assign c_dma.ready = dma_ready;

    function automatic logic [15:0] rdata(input logic [14:0] addr);
        return {1'b0, addr} ^ 16'hBE6F;
    endfunction

    // Core models: not reset, so a response already in flight still shows up on dma.resp.
    always @(posedge mclk) begin
        a_dma.resp <= a_dma.en & dma_ready;
        a_dma.dout <= rdata(a_dma.addr);
        b_dma.resp <= b_dma.en & dma_ready;
        b_dma.dout <= rdata(b_dma.addr);
        c_dma.resp <= c_dma.en & dma_ready;
        c_dma.dout <= rdata(c_dma.addr);
    end

    dma_arbiter #(.PRIORITY_MODE(0), .MAX_BURST(4)) u_dut_a (
        .mclk(mclk), .reset_n(reset_n), .m0(a_m0), .m1(a_m1), .dma(a_dma), .arb_owner(a_owner)
    );
    dma_arbiter #(.PRIORITY_MODE(0), .MAX_BURST(1)) u_dut_b (
        .mclk(mclk), .reset_n(reset_n), .m0(b_m0), .m1(b_m1), .dma(b_dma), .arb_owner(b_owner)
    );
    dma_arbiter #(.PRIORITY_MODE(1), .MAX_BURST(0)) u_dut_c (
        .mclk(mclk), .reset_n(reset_n), .m0(c_m0), .m1(c_m1), .dma(c_dma), .arb_owner(c_owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard on instance a: each accepted beat queues the read data its master should
    // see; each response pops and compares. Responses are handled before new acceptances.
    task automatic sb_step();
        logic [15:0] e;
        if (a_m0.resp) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb m0 resp: got unexpected response expected none");
            end else begin
                e = q0.pop_front();
                if (a_m0.dout !== e) begin
                    errors++;
                    $display("FAIL sb m0 dout: got %0h expected %0h", a_m0.dout, e);
                end
            end
        end
        if (a_m1.resp) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb m1 resp: got unexpected response expected none");
            end else begin
                e = q1.pop_front();
                if (a_m1.dout !== e) begin
                    errors++;
                    $display("FAIL sb m1 dout: got %0h expected %0h", a_m1.dout, e);
                end
            end
        end
        if (a_m0.ready) q0.push_back(rdata(m0_addr));
        if (a_m1.ready) q1.push_back(rdata(m1_addr));
    endtask

    task automatic drive(input logic e0, input logic e1, input logic rdy);
        m0_en     = e0;
        m1_en     = e1;
        dma_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge mclk);
        sb_step();
        next_cycle();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        next_cycle();
    endtask

    // {m0_en, m1_en, dma_ready} -> {arb_owner, dma_en, m0_ready, m1_ready, m0_resp, m1_resp}
    typedef struct packed {
        logic       e0;
        logic       e1;
        logic       rdy;
        logic [1:0] own;
        logic       den;
        logic       r0;
        logic       r1;
        logic       p0;
        logic       p1;
    } vec_t;

    localparam int NumVec = 19;
    vec_t vecs[NumVec];

    logic [6:0]  act_v, exp_v;
    logic [14:0] exp_addr;

    initial begin
        // in: {en0 en1 rdy}, own, out: {den r0 r1 p0 p1}
        vecs[0]  = {3'b101, 2'b00, 5'b00000}; // request from idle, no grant yet
        vecs[1]  = {3'b101, 2'b10, 5'b11000}; // m0 granted, first beat
        vecs[2]  = {3'b101, 2'b10, 5'b11010}; // second beat, first response
        vecs[3]  = {3'b110, 2'b10, 5'b10010}; // stall with m1 waiting
        vecs[4]  = {3'b110, 2'b10, 5'b10000};
        vecs[5]  = {3'b110, 2'b10, 5'b10000};
        vecs[6]  = {3'b110, 2'b10, 5'b10000};
        vecs[7]  = {3'b110, 2'b10, 5'b10000};
        vecs[8]  = {3'b111, 2'b10, 5'b11000}; // beat 3
        vecs[9]  = {3'b111, 2'b10, 5'b11010}; // beat 4, limit reached
        vecs[10] = {3'b111, 2'b11, 5'b10110}; // m1 owns, m0 response still arrives
        vecs[11] = {3'b111, 2'b11, 5'b10101};
        vecs[12] = {3'b111, 2'b11, 5'b10101};
        vecs[13] = {3'b111, 2'b11, 5'b10101}; // m1 beat 4
        vecs[14] = {3'b111, 2'b10, 5'b11001}; // back to m0
        vecs[15] = {3'b011, 2'b10, 5'b00010}; // m0 drops en: release
        vecs[16] = {3'b011, 2'b11, 5'b10100}; // direct handover to m1
        vecs[17] = {3'b001, 2'b11, 5'b00001}; // m1 drops en
        vecs[18] = {3'b001, 2'b00, 5'b00000}; // idle

        m0_addr = 15'h0080; m0_din = 16'h1111; m0_we = 2'b11; m0_pri = 1'b1;
        m1_addr = 15'h0123; m1_din = 16'h2222; m1_we = 2'b01; m1_pri = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;

        // Reset state.
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        chk("reset owner", 32'(a_owner), 32'd0);
        chk("reset dma_en", 32'(a_dma.en), 32'd0);
        chk("reset dma_addr", 32'(a_dma.addr), 32'd0);
        reset_n = 1'b1;
        next_cycle();

        // Vector table on instance a.
        for (int i = 0; i < NumVec; i++) begin
            drive(vecs[i].e0, vecs[i].e1, vecs[i].rdy);
            @(negedge mclk);
            act_v = {a_owner, a_dma.en, a_m0.ready, a_m1.ready, a_m0.resp, a_m1.resp};
            exp_v = {vecs[i].own, vecs[i].den, vecs[i].r0, vecs[i].r1, vecs[i].p0, vecs[i].p1};
            chk($sformatf("row%0d outputs", i), 32'(act_v), 32'(exp_v));
            exp_addr = vecs[i].own[1] ? (vecs[i].own[0] ? m1_addr : m0_addr) : 15'd0;
            chk($sformatf("row%0d dma_addr", i), 32'(a_dma.addr), 32'(exp_addr));
            if (i == 1) chk("m0 write data to core", 32'({a_dma.din, a_dma.we, a_dma.pri}),
                            32'({16'h1111, 2'b11, 1'b1}));
            if (i == 2) chk("m0_dout beef", 32'(a_m0.dout), 32'h0000BEEF);
            if (i == 10) chk("m1 write data to core", 32'({a_dma.din, a_dma.we, a_dma.pri}),
                             32'({16'h2222, 2'b01, 1'b0}));
            sb_step();
            next_cycle();
        end

        // Reset in the middle of a transfer with a response in flight.
        drive(1'b1, 1'b1, 1'b1);
        repeat (3) idle_cycle();
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("mid-reset owner", 32'(a_owner), 32'd0);
        chk("mid-reset dma", 32'({a_dma.en, a_dma.addr, a_dma.din, a_dma.we, a_dma.pri}), 32'd0);
        chk("mid-reset ready/resp", 32'({a_m0.ready, a_m1.ready, a_m0.resp, a_m1.resp}), 32'd0);
        chk("mid-reset dout", 32'({a_m0.dout, a_m1.dout}), 32'd0);
        @(negedge mclk);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        next_cycle();
        @(negedge mclk);
        chk("post-reset grant", 32'({a_owner, a_m0.ready}), 32'({2'b10, 1'b1}));
        sb_step();
        next_cycle();

        // Round-robin with burst 1 on instance b: grants alternate every cycle.
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        idle_cycle();
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge mclk);
            chk($sformatf("rr cycle%0d", i), 32'({b_owner, b_m0.ready, b_m1.ready}),
                (i % 2 == 1) ? 32'({2'b10, 2'b10}) : 32'({2'b11, 2'b01}));
            sb_step();
            next_cycle();
        end

        // Fixed priority, unlimited burst on instance c.
        do_reset();
        drive(1'b1, 1'b1, 1'b1);
        idle_cycle();
        for (int i = 1; i <= 22; i++) begin
            @(negedge mclk);
            chk($sformatf("fixed beat%0d", i), 32'({c_owner, c_m0.ready, c_m1.ready}),
                32'({2'b10, 2'b10}));
            sb_step();
            next_cycle();
        end
        drive(1'b0, 1'b1, 1'b1);
        @(negedge mclk);
        chk("fixed release", 32'({c_owner, c_dma.en}), 32'({2'b10, 1'b0}));
        sb_step();
        next_cycle();
        @(negedge mclk);
        chk("fixed m1 granted", 32'({c_owner, c_m1.ready, c_dma.addr}), 32'({2'b11, 1'b1, m1_addr}));
        sb_step();
        next_cycle();

        // Drain and confirm every accepted beat of instance a got its response.
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) idle_cycle();
        chk("sb drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
